// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS phase controller.
package dds_pkg;

    localparam int DEF_ACC_W  = 12;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with quarter-wave decode.
// Output registers are loaded from the next accumulator value, so they always
// show the sample for the phase the accumulator currently holds.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ACC_W-1:0]  load_val,
    input  logic              adv,
    input  logic [ACC_W-1:0]  ftw,
    input  logic              live,
    output logic              carry,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mirror,
    output logic              sign_bit,
    output logic              sample_valid
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W:0]    sum;
    logic [1:0]        quad;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              mirror_q, mirror_d;
    logic              sign_q, sign_d;
    logic              valid_q, valid_d;

    // Next phase, wrap carry, and decode of the next phase (zeroed when not live)
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, ftw};
        carry = adv & sum[ACC_W];
        acc_d = acc_q;
        if (load)
            acc_d = load_val;
        else if (adv)
            acc_d = sum[ACC_W-1:0];
        quad       = acc_d[ACC_W-1 -: 2];
        idx        = acc_d[ACC_W-3 -: ADDR_W];
        rom_addr_d = '0;
        mirror_d   = 1'b0;
        sign_d     = 1'b0;
        valid_d    = live;
        if (live) begin
            rom_addr_d = quad[0] ? ~idx : idx;
            mirror_d   = quad[0];
            sign_d     = quad[1];
        end
    end

    // Accumulator and registered sample outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            rom_addr_q <= '0;
            mirror_q   <= 1'b0;
            sign_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            rom_addr_q <= rom_addr_d;
            mirror_q   <= mirror_d;
            sign_q     <= sign_d;
            valid_q    <= valid_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign mirror       = mirror_q;
    assign sign_bit     = sign_q;
    assign sample_valid = valid_q;

endmodule

// File: rtl/dds_phase_ctrl.sv
// DDS phase controller: config handshake, IDLE/RUN/FINISH sequencing and
// period counting around the dds_phase_acc accumulator.
// Optional feature: DDS_PHASE_OFFSET_EN adds cfg_phase, the start phase of a run.
module dds_phase_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [CNT_W-1:0]  cfg_bursts,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [ACC_W-1:0]  cfg_phase,
`endif
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mirror,
    output logic              sign_bit,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  period_cnt
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [CNT_W-1:0] bursts_q, bursts_d;
    // Run copies: a handshake in the start cycle must not alter the run it starts
    logic [ACC_W-1:0] run_ftw_q, run_ftw_d;
    logic [CNT_W-1:0] run_bursts_q, run_bursts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0] start_phase;
    logic             acc_load, acc_adv, carry, live;

`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_W-1:0] phase_q, phase_d;

    // Start phase captured at the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase_q <= '0;
        else      phase_q <= phase_d;
    end

    assign phase_d     = (state_q == IDLE && cfg_valid) ? cfg_phase : phase_q;
    assign start_phase = phase_q;
`else
    assign start_phase = '0;
`endif

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, config latch and period counter
    always_comb begin
        state_d      = state_q;
        ftw_d        = ftw_q;
        bursts_d     = bursts_q;
        run_ftw_d    = run_ftw_q;
        run_bursts_d = run_bursts_q;
        cnt_d        = cnt_q;
        acc_load     = 1'b0;
        acc_adv      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    ftw_d    = cfg_ftw;
                    bursts_d = cfg_bursts;
                end
                if (start && ftw_q != '0) begin
                    state_d      = RUN;
                    run_ftw_d    = ftw_q;
                    run_bursts_d = bursts_q;
                    cnt_d        = '0;
                    acc_load     = 1'b1;
                end
            end
            RUN: begin
                acc_adv = 1'b1;
                if (carry)
                    cnt_d = cnt_inc;
                if (stop || (carry && run_bursts_q != '0 && cnt_inc == run_bursts_q))
                    state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        live = (state_d == RUN);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ftw_q        <= ACC_W'(1);
            bursts_q     <= '0;
            run_ftw_q    <= '0;
            run_bursts_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ftw_q        <= ftw_d;
            bursts_q     <= bursts_d;
            run_ftw_q    <= run_ftw_d;
            run_bursts_q <= run_bursts_d;
            cnt_q        <= cnt_d;
        end
    end

    dds_phase_acc #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst),
        .load         (acc_load),
        .load_val     (start_phase),
        .adv          (acc_adv),
        .ftw          (run_ftw_q),
        .live         (live),
        .carry        (carry),
        .rom_addr     (rom_addr),
        .mirror       (mirror),
        .sign_bit     (sign_bit),
        .sample_valid (sample_valid)
    );

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q == RUN) || (state_q == FINISH);
    assign done       = (state_q == FINISH);
    assign period_cnt = cnt_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed bench for dds_phase_ctrl; inputs change and outputs are sampled on
// the falling clock edge.
module tb_dds_phase_ctrl;

    logic        clk, rst;
    logic        cfg_valid, cfg_ready;
    logic [11:0] cfg_ftw;
    logic [7:0]  cfg_bursts;
    logic [11:0] cfg_phase;
    logic        start, stop;
    logic [5:0]  rom_addr;
    logic        mirror, sign_bit, sample_valid, busy, done;
    logic [7:0]  period_cnt;

    int tests = 0;
    int fails = 0;
    int j, qd, pos, ncyc, bad;
    logic [5:0] ea;

    dds_phase_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_bursts   (cfg_bursts),
`ifdef DDS_PHASE_OFFSET_EN
        .cfg_phase    (cfg_phase),
`endif
        .start        (start),
        .stop         (stop),
        .rom_addr     (rom_addr),
        .mirror       (mirror),
        .sign_bit     (sign_bit),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .period_cnt   (period_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {busy, done, sample_valid, mirror, sign_bit, rom_addr}
    function automatic logic [31:0] ov();
        return {21'd0, busy, done, sample_valid, mirror, sign_bit, rom_addr};
    endfunction

    function automatic logic [31:0] ev(input logic b, input logic d, input logic v,
                                       input logic m, input logic s, input logic [5:0] a);
        return {21'd0, b, d, v, m, s, a};
    endfunction

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [11:0] f, input logic [7:0] b);
        cfg_valid = 1'b1; cfg_ftw = f; cfg_bursts = b;
        nedge();
        cfg_valid = 1'b0;
    endtask

    // Pulse start; returns at the falling edge where sample 1 is visible
    task automatic go();
        start = 1'b1;
        nedge();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        nedge();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_ftw = '0; cfg_bursts = '0;
        cfg_phase = '0; start = 1'b0; stop = 1'b0;
        #3;
        check("reset_outputs", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        check("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("reset_period_cnt", {24'd0, period_cnt}, 32'd0);
        nedge();
        rst = 1'b1;
        nedge();

        // ftw = 0: start ignored
        cfg(12'd0, 8'd0);
        go();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done || sample_valid || !cfg_ready) bad++;
            nedge();
        end
        check("ftw0_start_ignored", bad, 0);

        // ftw=16, bursts=2: 512 samples then one FINISH cycle
        cfg(12'd16, 8'd2);
        go();
        for (int k = 1; k <= 512; k++) begin
            j   = (k - 1) % 256;
            qd  = j / 64;
            pos = j % 64;
            ea  = (qd % 2 == 1) ? 6'(63 - pos) : 6'(pos);
            check("burst_sample", ov(), ev(1, 0, 1, qd[0], qd[1], ea));
            if (k == 257) check("burst_cnt_mid", {24'd0, period_cnt}, 32'd1);
            nedge();
        end
        check("burst_finish", ov(), ev(1, 1, 0, 0, 0, 6'd0));
        check("burst_finish_cnt", {24'd0, period_cnt}, 32'd2);
        check("burst_finish_ready", {31'd0, cfg_ready}, 32'd0);
        nedge();
        check("burst_idle", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        check("burst_idle_cnt_hold", {24'd0, period_cnt}, 32'd2);

        // Continuous run, stop after 300 samples
        cfg(12'd64, 8'd0);
        go();
        repeat (299) nedge();
        check("cont_sample300_valid", {31'd0, sample_valid}, 32'd1);
        halt();
        check("cont_stop_finish", ov(), ev(1, 1, 0, 0, 0, 6'd0));
        check("cont_stop_cnt", {24'd0, period_cnt}, 32'd4);
        nedge();
        check("cont_stop_idle", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        halt();
        check("stop_in_idle_ignored", ov(), ev(0, 0, 0, 0, 0, 6'd0));

        // Handshake coincident with start: old ftw for this run, new for the next
        cfg(12'd16, 8'd1);
        cfg_valid = 1'b1; cfg_ftw = 12'd32; cfg_bursts = 8'd0;
        go();
        cfg_valid = 1'b0;
        check("coinc_s1", ov(), ev(1, 0, 1, 0, 0, 6'd0));
        nedge();
        check("coinc_s2_old_ftw", ov(), ev(1, 0, 1, 0, 0, 6'd1));
        start = 1'b1;
        nedge();
        start = 1'b0;
        check("coinc_s3", ov(), ev(1, 0, 1, 0, 0, 6'd2));
        nedge();
        check("start_in_run_ignored", ov(), ev(1, 0, 1, 0, 0, 6'd3));
        halt();
        check("coinc_finish", ov(), ev(1, 1, 0, 0, 0, 6'd0));
        nedge();
        go();
        check("next_run_s1", ov(), ev(1, 0, 1, 0, 0, 6'd0));
        nedge();
        check("next_run_s2_new_ftw", ov(), ev(1, 0, 1, 0, 0, 6'd2));
        halt();
        nedge();

        // Stop coinciding with the terminal carry: a single done
        cfg(12'd2048, 8'd1);
        go();
        check("term_s1", ov(), ev(1, 0, 1, 0, 0, 6'd0));
        nedge();
        check("term_s2", ov(), ev(1, 0, 1, 0, 1, 6'd0));
        halt();
        check("term_finish", ov(), ev(1, 1, 0, 0, 0, 6'd0));
        check("term_cnt", {24'd0, period_cnt}, 32'd1);
        nedge();
        check("term_idle", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        nedge();
        check("term_single_done", {31'd0, done}, 32'd0);

        // Period counter saturation
        cfg(12'd2048, 8'd0);
        go();
        repeat (600) nedge();
        check("sat_cnt", {24'd0, period_cnt}, 32'd255);
        check("sat_busy", {31'd0, busy}, 32'd1);
        halt();
        check("sat_finish_done", {31'd0, done}, 32'd1);
        nedge();

        // Asynchronous reset mid-run
        cfg(12'd16, 8'd0);
        go();
        repeat (99) nedge();
        #2 rst = 1'b0;
        #1;
        check("rst_mid_outputs", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        check("rst_mid_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_mid_cnt", {24'd0, period_cnt}, 32'd0);
        nedge();
        check("rst_held_no_done", ov(), ev(0, 0, 0, 0, 0, 6'd0));
        rst = 1'b1;
        nedge();
        cfg(12'd16, 8'd1);
        go();
        check("post_rst_s1", ov(), ev(1, 0, 1, 0, 0, 6'd0));
        ncyc = 1;
        while (!done && ncyc < 300) begin
            nedge();
            ncyc++;
        end
        check("post_rst_done_cycle", ncyc, 257);
        check("post_rst_cnt", {24'd0, period_cnt}, 32'd1);
        nedge();

`ifdef DDS_PHASE_OFFSET_EN
        // Start phase offset into quadrant 1
        cfg_phase = 12'h400;
        cfg(12'd16, 8'd0);
        go();
        check("offset_s1", ov(), ev(1, 0, 1, 1, 0, 6'd63));
        nedge();
        check("offset_s2", ov(), ev(1, 0, 1, 1, 0, 6'd62));
        halt();
        nedge();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dds_phase_ctrl.md
DDS_PHASE_CTRL -- requirements
Module: dds_phase_ctrl

Interface
REQ-001 Parameter ACC_W, default 12, phase accumulator width; the top 2 bits are the quadrant and the next ADDR_W bits are the ROM index.
REQ-002 Parameter ADDR_W, default 6, quarter-wave sine ROM address width.
REQ-003 Parameter CNT_W, default 8, burst period counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration acceptance; high only in IDLE.
REQ-008 cfg_ftw  in  ACC_W  frequency tuning word.
REQ-009 cfg_bursts  in  CNT_W  number of full periods to generate; 0 means continuous.
REQ-010 start  in  1  single-cycle run request.
REQ-011 stop  in  1  single-cycle abort request.
REQ-012 rom_addr  out  ADDR_W  registered ROM address.
REQ-013 mirror  out  1  registered, high in quadrants 1 and 3.
REQ-014 sign_bit  out  1  registered, high in quadrants 2 and 3.
REQ-015 sample_valid  out  1  high while rom_addr/mirror/sign_bit are a live sample.
REQ-016 busy  out  1  high in RUN and FINISH.
REQ-017 done  out  1  one-cycle pulse on run completion.
REQ-018 period_cnt  out  CNT_W  completed periods in the current run.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, RUN and FINISH, encoded as a 2-bit enum.
REQ-020 In IDLE, the cfg_valid&&cfg_ready handshake SHALL latch cfg_ftw and cfg_bursts into ftw_q and bursts_q.
REQ-021 In IDLE, start with ftw_q!=0 SHALL go to RUN and clear acc and period_cnt; start with ftw_q==0 SHALL be ignored.
REQ-022 If handshake and start occur in the same IDLE cycle, the run SHALL use the previously latched ftw_q/bursts_q; the new values apply to the next run.
REQ-023 In RUN, acc SHALL advance by ftw_q modulo 2^ACC_W every cycle, and sample_valid SHALL be 1.
REQ-024 Quadrant q = acc[ACC_W-1:ACC_W-2] and index i = acc[ACC_W-3 -: ADDR_W].
REQ-025 rom_addr SHALL be i in q=0 and q=2, and ~i in q=1 and q=3.
REQ-026 mirror SHALL equal q[0], and sign_bit SHALL equal q[1].
REQ-027 Latency: the first sample (addr 0, mirror 0, sign 0) SHALL appear the cycle after start is sampled.
REQ-028 An accumulator carry-out SHALL increment period_cnt, saturating at 2^CNT_W-1.
REQ-029 If bursts_q!=0 and a carry-out brings period_cnt to bursts_q, the FSM SHALL go to FINISH.
REQ-030 stop in RUN SHALL go to FINISH; stop coinciding with the terminal carry SHALL produce exactly one done.
REQ-031 FINISH SHALL last exactly one cycle: done=1, sample_valid=0, rom_addr/mirror/sign_bit forced to 0; then the FSM SHALL return to IDLE.
REQ-032 start in RUN or FINISH, and stop in IDLE, SHALL be ignored.
REQ-033 period_cnt SHALL hold its final value in IDLE until the next start.

Reset
REQ-034 On rst low, the FSM SHALL go to IDLE immediately, regardless of state (including mid-run).
REQ-035 Reset values: acc=0, ftw_q=1, bursts_q=0, period_cnt=0, rom_addr/mirror/sign_bit/sample_valid/busy/done=0, cfg_ready=1.
REQ-036 Reset mid-run SHALL NOT pulse done.

Configuration
REQ-037 With DDS_PHASE_OFFSET_EN defined: an input cfg_phase [ACC_W-1:0] SHALL be latched at the handshake, and start SHALL load acc with it instead of 0.
REQ-038 With DDS_PHASE_OFFSET_EN undefined: the port SHALL be absent, and start SHALL load acc with 0.

Structure
REQ-039 Package dds_pkg SHALL hold the state enum type and the default ACC_W/ADDR_W/CNT_W localparams.
REQ-040 The accumulator plus quadrant/address decode SHALL be sub-module dds_phase_acc; the FSM, handshake and counter SHALL stay in dds_phase_ctrl.

Verification
REQ-041 cfg ftw=16, bursts=2; start -> 512 samples, addr sequence 0..63, 63..0, 0..63, 63..0 per period with sign_bit 0,0,1,1 per quarter; done on cycle 513; period_cnt=2.
REQ-042 cfg ftw=0; start -> FSM stays in IDLE, no sample_valid, no done.
REQ-043 bursts=0, ftw=64; stop after 300 cycles -> FINISH for 1 cycle, done pulse, period_cnt=4.
REQ-044 rst low at cycle 100 of a run -> all outputs at reset values asynchronously, no done; a subsequent start works normally.
REQ-045 Handshake (ftw=32) coincident with start while ftw_q=16 -> run steps addr by 1; the next run steps by 2.
REQ-046 With DDS_PHASE_OFFSET_EN, cfg_phase=0x400, ftw=16 -> first sample addr 63, mirror 1, sign 0.
